// File: rtl/addsub_dispatch.sv
// addsub_dispatch: sign-magnitude request dispatcher for the AddSub unit.
// Optional watchdog on the finish wait: ADDSUB_DISPATCH_WATCHDOG_EN.
module addsub_dispatch #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_mag,
  input  logic        a_neg,
  input  logic [31:0] b_mag,
  input  logic        b_neg,
  input  logic        op_sub,
  output logic [31:0] as_A,
  output logic [31:0] as_B,
  output logic [3:0]  as_control,
  output logic        as_start,
  input  logic        as_finish,
  input  logic        as_sign,
  input  logic [31:0] as_C,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res_mag,
  output logic        res_neg,
  output logic        res_ovf,
  output logic        res_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic        a_neg_q;
  logic        ovf_q;
  logic        b_eff;
  logic [32:0] mag_sum;
  logic        ovf_in;
  logic        accept;
  logic        finish_ok;
  logic        timeout;
  logic [31:0] c_neg;
  logic [31:0] conv_mag;
  logic        conv_neg;

  assign b_eff     = b_neg ^ op_sub;
  assign mag_sum   = {1'b0, a_mag} + {1'b0, b_mag};
  assign ovf_in    = (a_neg == b_eff) & mag_sum[32];
  assign accept    = in_valid & in_ready;
  assign finish_ok = (state == WAIT) & as_finish;

`ifdef ADDSUB_DISPATCH_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;

  // finish on the limit edge wins over the abort
  assign timeout = (state == WAIT) & ~as_finish
                 & (wd_cnt == CW'(TIMEOUT - 1));

  // wait-cycle counter, cleared while issuing
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // abort flag: set on timeout, cleared by a real result
  always_ff @(posedge clock) begin
    if (reset) begin
      res_err <= 1'b0;
    end else if (finish_ok) begin
      res_err <= 1'b0;
    end else if (timeout) begin
      res_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT == 0);
  assign timeout    = 1'b0;
  assign res_err    = 1'b0;
`endif

  // two's-complement-with-sign back to sign-magnitude
  always_comb begin
    c_neg    = ~as_C + 32'd1;
    conv_mag = as_C;
    conv_neg = 1'b0;
    if (ovf_q) begin
      conv_mag = 32'hFFFF_FFFF;
      conv_neg = a_neg_q;
    end else if (as_sign) begin
      conv_mag = c_neg;
      conv_neg = 1'b1;
    end
    if (conv_mag == 32'd0) begin
      conv_neg = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    as_start  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        as_start = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (as_finish | timeout) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand capture on accept, result capture on finish/abort
  always_ff @(posedge clock) begin
    if (reset) begin
      as_A       <= '0;
      as_B       <= '0;
      as_control <= 4'b1000;
      a_neg_q    <= 1'b0;
      ovf_q      <= 1'b0;
      res_mag    <= '0;
      res_neg    <= 1'b0;
      res_ovf    <= 1'b0;
    end else begin
      if (accept) begin
        as_A       <= a_mag;
        as_B       <= b_mag;
        as_control <= {2'b10, a_neg, b_eff};
        a_neg_q    <= a_neg;
        ovf_q      <= ovf_in;
      end
      if (finish_ok) begin
        res_mag <= conv_mag;
        res_neg <= conv_neg;
        res_ovf <= ovf_q;
      end else if (timeout) begin
        res_mag <= '0;
        res_neg <= 1'b0;
        res_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_dispatch.sv
// tb_addsub_dispatch: scoreboard bench for addsub_dispatch.
// Bench plays the AddSub unit and the downstream consumer.
module tb_addsub_dispatch;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_mag;
  logic        a_neg;
  logic [31:0] b_mag;
  logic        b_neg;
  logic        op_sub;
  logic [31:0] as_A;
  logic [31:0] as_B;
  logic [3:0]  as_control;
  logic        as_start;
  logic        as_finish;
  logic        as_sign;
  logic [31:0] as_C;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_mag;
  logic        res_neg;
  logic        res_ovf;
  logic        res_err;

  typedef struct packed {
    logic [31:0] mag;
    logic        neg;
    logic        ovf;
    logic        err;
  } res_t;

  res_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  addsub_dispatch #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_mag(a_mag), .a_neg(a_neg),
    .b_mag(b_mag), .b_neg(b_neg), .op_sub(op_sub),
    .as_A(as_A), .as_B(as_B),
    .as_control(as_control), .as_start(as_start),
    .as_finish(as_finish), .as_sign(as_sign), .as_C(as_C),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_mag(res_mag), .res_neg(res_neg),
    .res_ovf(res_ovf), .res_err(res_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic an,
                      input logic [31:0] b, input logic bn,
                      input logic sub);
    a_mag = a; a_neg = an; b_mag = b; b_neg = bn; op_sub = sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue_check(input logic [3:0] ctl, input string nm);
    checks++;
    if (as_start !== 1'b1 || in_ready !== 1'b0 || as_control !== ctl) begin
      errors++;
      $display("FAIL %s issue: start=%b rdy=%b ctl=%b want start=1 rdy=0 ctl=%b",
               nm, as_start, in_ready, as_control, ctl);
    end
    tick();
    checks++;
    if (as_start !== 1'b0 || as_control !== ctl) begin
      errors++;
      $display("FAIL %s wait: start=%b ctl=%b want start=0 ctl=%b",
               nm, as_start, as_control, ctl);
    end
  endtask

  task automatic respond(input int lat, input logic sg, input logic [31:0] c);
    repeat (lat) tick();
    as_finish = 1'b1; as_sign = sg; as_C = c;
    tick();
    as_finish = 1'b0; as_sign = 1'b0; as_C = 32'h0;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || as_start !== 1'b0 || out_valid !== 1'b0 ||
        as_A !== 32'h0 || as_B !== 32'h0 || as_control !== 4'b1000 ||
        res_mag !== 32'h0 || res_neg !== 1'b0 || res_ovf !== 1'b0 ||
        res_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b st=%b ov=%b A=%h B=%h ctl=%b res=%h/%b/%b/%b want 1 0 0 0 0 1000 0/0/0/0",
               in_ready, as_start, out_valid, as_A, as_B, as_control,
               res_mag, res_neg, res_ovf, res_err);
    end
  endtask

  task automatic test_basic;
    res_t e;
    send(32'd10, 1'b0, 32'd20, 1'b0, 1'b0);
    sbq.push_back('{mag: 32'd30, neg: 1'b0, ovf: 1'b0, err: 1'b0});
    issue_check(4'b1000, "basic");
    out_ready = 1'b1;
    respond(2, 1'b0, 32'd30);
    e = sbq.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {res_mag, res_neg, res_ovf, res_err} !== e) begin
      errors++;
      $display("FAIL basic result: v=%b res=%h/%b/%b/%b want v=1 %h/%b/%b/%b",
               out_valid, res_mag, res_neg, res_ovf, res_err,
               e.mag, e.neg, e.ovf, e.err);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic handshake: v=%b rdy=%b want v=0 rdy=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_overflow;
    res_t e;
    send(32'hFFFF_FFFF, 1'b0, 32'd1, 1'b0, 1'b0);
    sbq.push_back('{mag: 32'hFFFF_FFFF, neg: 1'b0, ovf: 1'b1, err: 1'b0});
    issue_check(4'b1000, "ovf_pos");
    respond(3, 1'b0, 32'h0);
    e = sbq.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {res_mag, res_neg, res_ovf, res_err} !== e) begin
      errors++;
      $display("FAIL ovf_pos: v=%b res=%h/%b/%b/%b want v=1 %h/%b/%b/%b",
               out_valid, res_mag, res_neg, res_ovf, res_err,
               e.mag, e.neg, e.ovf, e.err);
    end
    consume();
    send(32'hFFFF_FFFF, 1'b1, 32'd1, 1'b1, 1'b0);
    sbq.push_back('{mag: 32'hFFFF_FFFF, neg: 1'b1, ovf: 1'b1, err: 1'b0});
    issue_check(4'b1011, "ovf_neg");
    respond(1, 1'b1, 32'h0);
    e = sbq.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {res_mag, res_neg, res_ovf, res_err} !== e) begin
      errors++;
      $display("FAIL ovf_neg: v=%b res=%h/%b/%b/%b want v=1 %h/%b/%b/%b",
               out_valid, res_mag, res_neg, res_ovf, res_err,
               e.mag, e.neg, e.ovf, e.err);
    end
    consume();
  endtask

  task automatic test_backpressure;
    res_t e;
    send(32'd5, 1'b0, 32'd7, 1'b0, 1'b1);
    sbq.push_back('{mag: 32'd2, neg: 1'b1, ovf: 1'b0, err: 1'b0});
    issue_check(4'b1001, "neg");
    respond(0, 1'b1, 32'hFFFF_FFFE);
    e = sbq.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {res_mag, res_neg, res_ovf, res_err} !== e) begin
        errors++;
        $display("FAIL hold[%0d]: v=%b rdy=%b res=%h/%b/%b/%b want v=1 rdy=0 %h/%b/%b/%b",
                 i, out_valid, in_ready, res_mag, res_neg, res_ovf, res_err,
                 e.mag, e.neg, e.ovf, e.err);
      end
      tick();
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res_mag !== 32'd2) begin
      errors++;
      $display("FAIL release: v=%b rdy=%b mag=%h want v=0 rdy=1 mag=2",
               out_valid, in_ready, res_mag);
    end
  endtask

  task automatic test_zero;
    res_t e;
    for (int k = 0; k < 2; k++) begin
      send(32'd9, 1'b1, 32'd9, 1'b1, 1'b1);
      sbq.push_back('{mag: 32'd0, neg: 1'b0, ovf: 1'b0, err: 1'b0});
      issue_check(4'b1010, "zero");
      respond(2, (k == 1), 32'h0);
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {res_mag, res_neg, res_ovf, res_err} !== e) begin
        errors++;
        $display("FAIL zero[%0d]: v=%b res=%h/%b/%b/%b want v=1 %h/%b/%b/%b",
                 k, out_valid, res_mag, res_neg, res_ovf, res_err,
                 e.mag, e.neg, e.ovf, e.err);
      end
      consume();
    end
  endtask

  task automatic test_random;
    res_t e;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      logic an, bn, sb, be, ov;
      longint sa, sbv, s, av, bv;
      a  = (i < 4) ? 32'($urandom_range(0, 1000)) : $urandom;
      b  = (i < 4) ? 32'($urandom_range(0, 1000)) : $urandom;
      an = 1'($urandom_range(0, 1));
      bn = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      be = bn ^ sb;
      av = longint'(a);
      bv = longint'(b);
      sa = an ? -av : av;
      sbv = be ? -bv : bv;
      s  = sa + sbv;
      ov = (an == be) && (av + bv > 64'sh0_FFFF_FFFF);
      if (ov) e = '{mag: 32'hFFFF_FFFF, neg: an, ovf: 1'b1, err: 1'b0};
      else if (s < 0) e = '{mag: 32'(-s), neg: 1'b1, ovf: 1'b0, err: 1'b0};
      else e = '{mag: 32'(s), neg: 1'b0, ovf: 1'b0, err: 1'b0};
      send(a, an, b, bn, sb);
      sbq.push_back(e);
      issue_check({2'b10, an, be}, "rand");
      checks++;
      if (as_A !== a || as_B !== b) begin
        errors++;
        $display("FAIL rand operands: A=%h B=%h want %h %h", as_A, as_B, a, b);
      end
      respond(i % 3, (s < 0), 32'(s));
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {res_mag, res_neg, res_ovf, res_err} !== e) begin
        errors++;
        $display("FAIL rand[%0d]: v=%b res=%h/%b/%b/%b want v=1 %h/%b/%b/%b",
                 i, out_valid, res_mag, res_neg, res_ovf, res_err,
                 e.mag, e.neg, e.ovf, e.err);
      end
      consume();
    end
  endtask

  task automatic test_reset_mid_wait;
    int seen;
    send(32'd3, 1'b0, 32'd4, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || as_start !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait reset: rdy=%b st=%b v=%b want 1 0 0",
               in_ready, as_start, out_valid);
    end
    respond(0, 1'b0, 32'd7);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray finish: valid cycles=%0d rdy=%b want 0 1",
               seen, in_ready);
    end
  endtask

  task automatic test_watchdog;
    int k;
    send(32'd1, 1'b0, 32'd1, 1'b0, 1'b0);
    tick();
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
`ifdef ADDSUB_DISPATCH_WATCHDOG_EN
    checks++;
    if (k != 8 || out_valid !== 1'b1 || res_err !== 1'b1 ||
        res_mag !== 32'h0 || res_neg !== 1'b0 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL watchdog: cycles=%0d v=%b err=%b mag=%h want 8 1 1 0",
               k, out_valid, res_err, res_mag);
    end
    consume();
`else
    checks++;
    if (k != 100 || out_valid !== 1'b0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL no watchdog: cycles=%0d v=%b err=%b want 100 0 0",
               k, out_valid, res_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post watchdog: rdy=%b want 1", in_ready);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_mag = '0; a_neg = 1'b0; b_mag = '0; b_neg = 1'b0; op_sub = 1'b0;
    as_finish = 1'b0; as_sign = 1'b0; as_C = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_zero();
    test_random();
    test_reset_mid_wait();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
